// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI4-Lite response codes and master state encoding
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
endpackage

// File: rtl/axi_lite_master_if.sv
// axi_lite_master_if: AXI4-Lite AW/W/B/AR/R bus with master and slave views
interface axi_lite_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;
  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_valid;
  logic                    r_ready;
  modport master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
  modport slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator with response channel and cycle timeout
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [1:0]              rsp_resp_o,
  output logic                    rsp_timeout_o,
  axi_lite_master_if.master       m
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int SW = DATA_WIDTH / 8;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic aw_valid_q, aw_valid_d, w_valid_q, w_valid_d, ar_valid_q, ar_valid_d;
  logic b_ready_q, b_ready_d, r_ready_q, r_ready_d;
  logic rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  logic is_wr, done, expired;
  assign is_wr   = state_q == WRITE;
  assign done    = is_wr ? m.b_valid : m.r_valid;
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign cmd_ready_o   = (state_q == IDLE) && !rst;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_resp_o    = rsp_resp_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign m.aw_addr  = addr_q;
  assign m.ar_addr  = addr_q;
  assign m.w_data   = wdata_q;
  assign m.w_strb   = wstrb_q;
  assign m.aw_valid = aw_valid_q;
  assign m.w_valid  = w_valid_q;
  assign m.ar_valid = ar_valid_q;
  assign m.b_ready  = b_ready_q;
  assign m.r_ready  = r_ready_q;
  // Next state and next registered outputs; completion takes priority over the timeout abort
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    aw_valid_d    = aw_valid_q;
    w_valid_d     = w_valid_q;
    ar_valid_d    = ar_valid_q;
    b_ready_d     = b_ready_q;
    r_ready_d     = r_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        state_d    = cmd_write_i ? WRITE : READ;
        addr_d     = cmd_addr_i;
        wdata_d    = cmd_wdata_i;
        wstrb_d    = cmd_wstrb_i;
        aw_valid_d = cmd_write_i;
        w_valid_d  = cmd_write_i;
        b_ready_d  = cmd_write_i;
        ar_valid_d = !cmd_write_i;
        r_ready_d  = !cmd_write_i;
        cnt_d      = '0;
      end
      WRITE, READ: begin
        aw_valid_d = aw_valid_q && !m.aw_ready;
        w_valid_d  = w_valid_q && !m.w_ready;
        ar_valid_d = ar_valid_q && !m.ar_ready;
        cnt_d      = cnt_q + CW'(1);
        if (done || expired) begin
          state_d       = RESP;
          aw_valid_d    = 1'b0;
          w_valid_d     = 1'b0;
          ar_valid_d    = 1'b0;
          b_ready_d     = 1'b0;
          r_ready_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = !done;
          rsp_resp_d    = !done ? RESP_SLVERR : is_wr ? m.b_resp : m.r_resp;
          rsp_rdata_d   = (done && !is_wr) ? m.r_data : '0;
        end
      end
      RESP: if (rsp_ready_i) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_valid_q    <= 1'b0;
      w_valid_q     <= 1'b0;
      ar_valid_q    <= 1'b0;
      b_ready_q     <= 1'b0;
      r_ready_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      aw_valid_q    <= aw_valid_d;
      w_valid_q     <= w_valid_d;
      ar_valid_q    <= ar_valid_d;
      b_ready_q     <= b_ready_d;
      r_ready_q     <= r_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      cnt_q         <= cnt_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: table-driven and randomized checks of the AXI4-Lite master against a latency/response model
module tb_axi_lite_master;
  import axi_lite_pkg::*;
  localparam int T = 16;
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          ar_dly;
    int          rsp_dly;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        hang;
    int          hold;
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    logic        e_to;
    int          e_lat;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  int          checks = 0;
  int          failures = 0;
  axi_lite_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
  axi_lite_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_resp_o(rsp_resp), .rsp_timeout_o(rsp_timeout),
    .m(bus.master)
  );
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int comp;
    r = v;
    comp = v.wr ? ((v.aw_dly > v.w_dly ? v.aw_dly : v.w_dly) + 1 + v.rsp_dly) : (v.ar_dly + 1 + v.rsp_dly);
    r.e_to = v.hang || comp > T;
    r.e_lat = r.e_to ? T + 1 : comp + 1;
    r.e_resp = r.e_to ? RESP_SLVERR : v.resp;
    r.e_rdata = (r.e_to || v.wr) ? 32'h0 : v.rdata;
    return r;
  endfunction
  function automatic int high_cycles(input int d, input logic hang);
    return hang ? T : (d + 1 < T ? d + 1 : T);
  endfunction
  function automatic int hs_count(input int d, input logic hang);
    return (!hang && d < T) ? 1 : 0;
  endfunction
  task automatic clear_slave();
    bus.aw_ready = 0; bus.w_ready = 0; bus.ar_ready = 0;
    bus.b_valid = 0; bus.b_resp = 0; bus.r_valid = 0; bus.r_resp = 0; bus.r_data = 0;
  endtask
  task automatic run(input vec_t v, input string tag);
    int lat, aw_c, w_c, ar_c, aw_h, w_h, ar_h, aw_n, w_n, ar_n, bad, st_bad;
    logic sent;
    logic [1:0] r0;
    logic [31:0] d0;
    logic t0;
    lat = 0; aw_c = 0; w_c = 0; ar_c = 0; aw_h = 0; w_h = 0; ar_h = 0;
    aw_n = 0; w_n = 0; ar_n = 0; bad = 0; st_bad = 0; sent = 0;
    @(negedge clk);
    chk({tag, " cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.strb;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      cmd_valid = 0;
      if (rsp_valid) lat = n;
      else if (v.wr) begin
        if (!bus.b_ready || bus.r_ready || bus.ar_valid) bad++;
        if (bus.aw_valid && bus.aw_addr !== v.addr) bad++;
        if (bus.w_valid && (bus.w_data !== v.wdata || bus.w_strb !== v.strb)) bad++;
        bus.aw_ready = !v.hang && n > v.aw_dly;
        bus.w_ready = !v.hang && n > v.w_dly;
        if (bus.aw_valid) begin aw_h++; if (bus.aw_ready) begin aw_c++; aw_n = n; end end
        if (bus.w_valid) begin w_h++; if (bus.w_ready) begin w_c++; w_n = n; end end
        bus.b_resp = v.resp;
        bus.b_valid = !sent && aw_c > 0 && w_c > 0 && n >= (aw_n > w_n ? aw_n : w_n) + v.rsp_dly;
        if (bus.b_valid) sent = 1;
      end else begin
        if (!bus.r_ready || bus.b_ready || bus.aw_valid || bus.w_valid) bad++;
        if (bus.ar_valid && bus.ar_addr !== v.addr) bad++;
        bus.ar_ready = !v.hang && n > v.ar_dly;
        if (bus.ar_valid) begin ar_h++; if (bus.ar_ready) begin ar_c++; ar_n = n; end end
        bus.r_resp = v.resp;
        bus.r_data = v.rdata;
        bus.r_valid = !sent && ar_c > 0 && n >= ar_n + v.rsp_dly;
        if (bus.r_valid) sent = 1;
      end
    end
    clear_slave();
    chk({tag, " latency"}, lat, v.e_lat);
    chk({tag, " rsp_resp"}, rsp_resp, v.e_resp);
    chk({tag, " rsp_rdata"}, rsp_rdata, v.e_rdata);
    chk({tag, " rsp_timeout"}, rsp_timeout, v.e_to);
    chk({tag, " protocol"}, bad, 0);
    if (v.wr) begin
      chk({tag, " aw_hs"}, aw_c, hs_count(v.aw_dly, v.hang));
      chk({tag, " w_hs"}, w_c, hs_count(v.w_dly, v.hang));
      chk({tag, " aw_high"}, aw_h, high_cycles(v.aw_dly, v.hang));
      chk({tag, " w_high"}, w_h, high_cycles(v.w_dly, v.hang));
    end else begin
      chk({tag, " ar_hs"}, ar_c, hs_count(v.ar_dly, v.hang));
      chk({tag, " ar_high"}, ar_h, high_cycles(v.ar_dly, v.hang));
    end
    r0 = rsp_resp; d0 = rsp_rdata; t0 = rsp_timeout;
    rsp_ready = (v.hold == 0);
    for (int h = 1; h <= v.hold; h++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_resp !== r0 || rsp_rdata !== d0 || rsp_timeout !== t0 || cmd_ready) st_bad++;
      if (h == v.hold) rsp_ready = 1;
    end
    @(negedge clk);
    rsp_ready = 0;
    chk({tag, " rsp_stable"}, st_bad, 0);
    chk({tag, " rsp_done/cmd_ready"}, {rsp_valid, cmd_ready}, 2'b01);
  endtask
  vec_t tbl[10];
  vec_t v;
  int   bad;
  initial begin
    tbl[0] = '{1'b1, 32'h8,      32'h400,      4'hF, 0,  0, 0, 0,  2'b00, 32'h0,        1'b0, 0, 2'b00, 32'h0,        1'b0, 2};
    tbl[1] = '{1'b1, 32'h10,     32'hA5A5_0001, 4'h3, 3,  0, 0, 0,  2'b00, 32'h0,        1'b0, 1, 2'b00, 32'h0,        1'b0, 5};
    tbl[2] = '{1'b0, 32'h4,      32'h0,        4'h0, 0,  0, 0, 2,  2'b00, 32'h1,        1'b0, 0, 2'b00, 32'h1,        1'b0, 4};
    tbl[3] = '{1'b0, 32'hFFF0,   32'h0,        4'h0, 0,  0, 1, 1,  2'b11, 32'hDEADBEEF, 1'b0, 0, 2'b11, 32'hDEADBEEF, 1'b0, 4};
    tbl[4] = '{1'b0, 32'h20,     32'h0,        4'h0, 0,  0, 0, 0,  2'b00, 32'h1234,     1'b1, 0, 2'b10, 32'h0,        1'b1, 17};
    tbl[5] = '{1'b1, 32'h24,     32'h77,       4'h1, 1,  1, 0, 1,  2'b10, 32'h0,        1'b0, 0, 2'b10, 32'h0,        1'b0, 4};
    tbl[6] = '{1'b1, 32'h28,     32'h99,       4'hC, 15, 0, 0, 0,  2'b01, 32'h0,        1'b0, 0, 2'b01, 32'h0,        1'b0, 17};
    tbl[7] = '{1'b1, 32'h2C,     32'h55,       4'hF, 16, 0, 0, 0,  2'b00, 32'h0,        1'b0, 0, 2'b10, 32'h0,        1'b1, 17};
    tbl[8] = '{1'b0, 32'h30,     32'h0,        4'h0, 0,  0, 0, 15, 2'b00, 32'h55,       1'b0, 0, 2'b00, 32'h55,       1'b0, 17};
    tbl[9] = '{1'b1, 32'h34,     32'h1,        4'hF, 0,  0, 0, 1,  2'b00, 32'h0,        1'b0, 5, 2'b00, 32'h0,        1'b0, 3};
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    clear_slave();
    repeat (3) @(negedge clk);
    chk("reset cmd_ready", cmd_ready, 0);
    chk("reset valids", {bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready, bus.r_ready, rsp_valid, rsp_timeout}, 0);
    chk("reset data", {bus.aw_addr, bus.ar_addr, bus.w_data, bus.w_strb, rsp_rdata, rsp_resp}, 0);
    rst = 0;
    for (int i = 0; i < 10; i++) run(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 40; i++) begin
      v.wr = 1'($urandom_range(0, 1));
      v.addr = $urandom & 32'hFFFF_FFFC;
      v.wdata = $urandom;
      v.strb = 4'($urandom_range(0, 15));
      v.aw_dly = $urandom_range(0, 9);
      v.w_dly = $urandom_range(0, 9);
      v.ar_dly = $urandom_range(0, 9);
      v.rsp_dly = $urandom_range(0, 8);
      v.resp = 2'($urandom_range(0, 3));
      v.rdata = $urandom;
      v.hang = ($urandom_range(0, 7) == 0);
      v.hold = $urandom_range(0, 3);
      run(model(v), $sformatf("rnd%0d", i));
    end
    @(negedge clk);
    bus.b_valid = 1; bus.r_valid = 1; bus.b_resp = 2'b11; bus.r_data = 32'hCAFE;
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.b_ready || bus.r_ready || rsp_valid || !cmd_ready) bad++;
    end
    clear_slave();
    chk("idle ignores B/R", bad, 0);
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'hFACE; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 0;
    repeat (3) @(negedge clk);
    chk("mid-write aw/w valid", {bus.aw_valid, bus.w_valid}, 2'b11);
    rst = 1;
    @(negedge clk);
    chk("mid-reset valids", {bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready, bus.r_ready, rsp_valid, rsp_timeout}, 0);
    chk("mid-reset data", {bus.aw_addr, bus.w_data, bus.w_strb}, 0);
    chk("mid-reset cmd_ready", cmd_ready, 0);
    rst = 0;
    @(negedge clk);
    chk("post-reset cmd_ready", cmd_ready, 1);
    bad = 0;
    repeat (T + 2) begin
      @(negedge clk);
      if (rsp_valid || bus.aw_valid || bus.w_valid || bus.ar_valid) bad++;
    end
    chk("post-reset quiet", bad, 0);
    run(tbl[0], "after-reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

Single-outstanding AXI4-Lite initiator. Converts one command from an internal requester (test sequencer, DMA descriptor fetch, CPU-side bridge) into one AXI4-Lite write or read on the interconnect, then returns the response on a valid/ready channel. It drives the same AW/W/B/AR/R bus that our accelerator register slaves respond on. A cycle-count timeout prevents a hung responder from blocking the requester.

## Interface
- DATA_WIDTH, 32, data bus width; w_strb is DATA_WIDTH/8 bits
- ADDR_WIDTH, 32, address width
- TIMEOUT_CYCLES, 256, cycles allowed in WRITE/READ before abort; 0 disables the timeout
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE and not in reset
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  requester accepts response
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_resp  out  2  captured BRESP/RRESP, or SLVERR on timeout
- rsp_timeout  out  1  set when the transaction was aborted
- aw_addr / aw_valid / aw_ready  out / out / in  ADDR_WIDTH / 1 / 1  write address channel
- w_data / w_strb / w_valid / w_ready  out / out / out / in  DATA_WIDTH / DATA_WIDTH/8 / 1 / 1  write data channel
- b_resp / b_valid / b_ready  in / in / out  2 / 1 / 1  write response channel
- ar_addr / ar_valid / ar_ready  out / out / in  ADDR_WIDTH / 1 / 1  read address channel
- r_data / r_resp / r_valid / r_ready  in / in / in / out  DATA_WIDTH / 2 / 1 / 1  read data channel

## Operation
- FSM states: IDLE, WRITE, READ, RESP. Reset state is IDLE.
- IDLE: on cmd_valid && cmd_ready, register addr, data and strb, and clear flags aw_done, w_done and the timeout counter. Go to WRITE if cmd_write is 1, otherwise READ.
- WRITE:
  - aw_valid = !aw_done and w_valid = !w_done. Each channel drops independently on its own handshake and stays low afterwards.
  - b_ready is held at 1 for the whole state. B may complete in the same cycle as the last AW/W handshake, which covers responders that pulse b_valid for one cycle coincident with AW/W acceptance.
  - On b_valid: capture b_resp, then go to RESP.
- READ:
  - ar_valid is asserted until the AR handshake, then stays low.
  - r_ready is held at 1 for the whole state.
  - On r_valid: capture r_data and r_resp, then go to RESP.
- RESP:
  - rsp_valid = 1, with rsp_* outputs stable until rsp_ready.
  - On the rsp_valid && rsp_ready handshake, go to IDLE. cmd_ready rises in the following cycle.
- Timeout (when TIMEOUT_CYCLES > 0):
  - The counter (width $clog2(TIMEOUT_CYCLES+1)) increments every cycle spent in WRITE or READ.
  - When it reaches TIMEOUT_CYCLES-1 without completion, deassert all AXI valids/readies on the next edge and go to RESP with rsp_resp = 2'b10, rsp_timeout = 1, rsp_rdata = 0.
  - Abandoning valid is a deliberate fault-recovery exception to the AXI rule.
- Simultaneous completion and timeout in the same cycle: completion wins, and rsp_timeout = 0.
- B or R arriving with no transaction open (IDLE/RESP): ignored; b_ready and r_ready are 0 in those states.

## Timing
- Reset values:
  - aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, rsp_timeout = 0
  - aw_addr, ar_addr, w_data, w_strb, rsp_rdata, rsp_resp = 0
  - cmd_ready = 0 while rst is high
- Reset mid-transaction: all outputs return to reset values on the next edge. The command is dropped and no response is issued.
- All AXI and rsp outputs are registered. cmd_ready is decoded from the state register.
- Minimum latency with an always-ready responder that answers in the same cycle:
  - command handshake at edge 0
  - valids high in cycle 1
  - rsp_valid in cycle 2
- Latency with registered-ready responders (ready one cycle after valid, response in the handshake cycle or the next): rsp_valid in cycle 3 or 4.
- Throughput: at most one transaction in flight, no pipelining.

## Structure
- Shared package axi_lite_pkg holds:
  - response codes RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11
  - the master state encoding (IDLE/WRITE/READ/RESP)
- Single module. The timeout counter is small enough to stay inline, so no sub-module.

## Test plan
- Write 0x0000_0008 data 0x0000_0400 strb 0xF; responder accepts AW/W together and pulses b_valid for one cycle with OKAY -> AW/W each seen once, rsp_valid with rsp_resp = 00 and rsp_timeout = 0.
- Write where w_ready comes 3 cycles before aw_ready -> w_valid drops after its handshake, aw_valid holds until its own handshake, then one response is returned.
- Read 0x0000_0004; responder returns r_data 0x0000_0001, RRESP 00 two cycles after the AR handshake -> rsp_rdata = 0x0000_0001, rsp_resp = 00.
- Read from an unmapped address; responder returns 0xDEADBEEF with RRESP 11 -> rsp_rdata = 0xDEADBEEF, rsp_resp = 11.
- TIMEOUT_CYCLES = 16, responder never asserts ar_ready -> ar_valid drops after 16 cycles in READ; rsp_resp = 10, rsp_timeout = 1, rsp_rdata = 0.
- rsp_ready held low for 5 cycles, then rst pulsed during a later write in flight -> response held stable for the 5 cycles; after reset all valids are 0, no rsp_valid, and cmd_ready = 1 in the cycle after rst falls.
